// File: rtl/sdram_arb.sv
// Two-client SDRAM arbiter: video has priority, but the MMU is guaranteed a grant
// after MAX_VIDEO_WINS consecutive video wins while it was waiting.
module sdram_arb #(
    parameter int MAX_VIDEO_WINS = 4
) (
    input  logic        cache_clk,
    input  logic        reset,
    input  logic        v_rw_req,
    input  logic [31:0] v_address,
    input  logic        v_burst_len,
    output logic        v_bursting,
    input  logic        m_rw_req,
    input  logic        m_rw,
    input  logic [31:0] m_address,
    input  logic [15:0] m_write_data,
    input  logic        m_burst_len,
    output logic        m_bursting,
    output logic        sd_rw_req,
    output logic        sd_rw,
    output logic [31:0] sd_address,
    output logic [15:0] sd_write_data,
    output logic        sd_burst_len,
    input  logic        sd_bursting,
    output logic        owner_mmu
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [2:0] MAX_WINS = 3'(MAX_VIDEO_WINS);

    state_t     state, state_next;
    logic       owner_next;
    logic       sd_rw_req_next;
    logic [2:0] vcount, vcount_next;
    logic       owner_req;
    logic       grant_mmu;

    assign owner_req = owner_mmu ? m_rw_req : v_rw_req;
    assign grant_mmu = m_rw_req && (!v_rw_req || (vcount >= MAX_WINS));

    always_ff @(posedge cache_clk) begin
        if (!reset) begin
            state     <= IDLE;
            owner_mmu <= 1'b0;
            sd_rw_req <= 1'b0;
            vcount    <= 3'd0;
        end else begin
            state     <= state_next;
            owner_mmu <= owner_next;
            sd_rw_req <= sd_rw_req_next;
            vcount    <= vcount_next;
        end
    end

    // Ownership and the win counter only move at the IDLE grant; sd_bursting outside
    // REQ/BURST is deliberately ignored.
    always_comb begin
        state_next     = state;
        owner_next     = owner_mmu;
        sd_rw_req_next = 1'b0;
        vcount_next    = vcount;
        case (state)
            IDLE: begin
                if (v_rw_req || m_rw_req) begin
                    state_next     = REQ;
                    owner_next     = grant_mmu;
                    sd_rw_req_next = 1'b1;
                    if (grant_mmu || !m_rw_req)
                        vcount_next = 3'd0;
                    else if (vcount != 3'd7)
                        vcount_next = vcount + 3'd1;
                end
            end
            REQ: begin
                sd_rw_req_next = owner_req;
                if (!owner_req)
                    state_next = GAP;
                else if (sd_bursting)
                    state_next = BURST;
            end
            BURST: begin
                sd_rw_req_next = owner_req;
                if (!sd_bursting && !owner_req)
                    state_next = GAP;
            end
            GAP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign sd_address    = owner_mmu ? m_address    : v_address;
    assign sd_burst_len  = owner_mmu ? m_burst_len  : v_burst_len;
    assign sd_write_data = owner_mmu ? m_write_data : 16'h0000;
    assign sd_rw         = owner_mmu & m_rw;
    assign v_bursting    = sd_bursting & ~owner_mmu;
    assign m_bursting    = sd_bursting & owner_mmu;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: grants, priority/starvation, abort, isolation, reset.
module tb_sdram_arb;

    logic        cache_clk = 1'b0;
    logic        reset;
    logic        v_rw_req, v_burst_len, v_bursting;
    logic [31:0] v_address;
    logic        m_rw_req, m_rw, m_burst_len, m_bursting;
    logic [31:0] m_address;
    logic [15:0] m_write_data;
    logic        sd_rw_req, sd_rw, sd_burst_len, sd_bursting, owner_mmu;
    logic [31:0] sd_address;
    logic [15:0] sd_write_data;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_REQ   = 32'd1;
    localparam logic [31:0] S_BURST = 32'd2;
    localparam logic [31:0] S_GAP   = 32'd3;

    sdram_arb #(.MAX_VIDEO_WINS(4)) dut (
        .cache_clk    (cache_clk),
        .reset        (reset),
        .v_rw_req     (v_rw_req),
        .v_address    (v_address),
        .v_burst_len  (v_burst_len),
        .v_bursting   (v_bursting),
        .m_rw_req     (m_rw_req),
        .m_rw         (m_rw),
        .m_address    (m_address),
        .m_write_data (m_write_data),
        .m_burst_len  (m_burst_len),
        .m_bursting   (m_bursting),
        .sd_rw_req    (sd_rw_req),
        .sd_rw        (sd_rw),
        .sd_address   (sd_address),
        .sd_write_data(sd_write_data),
        .sd_burst_len (sd_burst_len),
        .sd_bursting  (sd_bursting),
        .owner_mmu    (owner_mmu)
    );

    always #5 cache_clk = ~cache_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge, and inputs changed there too.
    task automatic applyStimulus();
        @(posedge cache_clk);
        #1;
    endtask

    task automatic checkCore(input string tag, input logic [31:0] st, input logic req,
                             input logic own, input logic [2:0] vc);
        checkOutput({tag, ".state"},     32'(dut.state), st);
        checkOutput({tag, ".sd_rw_req"}, {31'd0, sd_rw_req}, {31'd0, req});
        checkOutput({tag, ".owner"},     {31'd0, owner_mmu}, {31'd0, own});
        checkOutput({tag, ".vcount"},    {29'd0, dut.vcount}, {29'd0, vc});
    endtask

    initial begin
        reset = 1'b0; v_rw_req = 1'b0; v_address = 32'h0; v_burst_len = 1'b0;
        m_rw_req = 1'b0; m_rw = 1'b0; m_address = 32'h0; m_write_data = 16'h0;
        m_burst_len = 1'b0; sd_bursting = 1'b0;
        applyStimulus();
        applyStimulus();
        checkCore("reset", S_IDLE, 1'b0, 1'b0, 3'd0);
        checkOutput("reset.v_bursting", {31'd0, v_bursting}, 32'd0);
        checkOutput("reset.m_bursting", {31'd0, m_bursting}, 32'd0);
        reset = 1'b1;
        applyStimulus();
        checkCore("idle", S_IDLE, 1'b0, 1'b0, 3'd0);

        // MMU-only write, then an 8-cycle isolated MMU burst with a video request waiting
        m_rw_req = 1'b1; m_rw = 1'b1; m_address = 32'h0000_1000; m_write_data = 16'hBEEF;
        m_burst_len = 1'b1; v_address = 32'h0000_2000;
        applyStimulus();
        checkCore("mwr", S_REQ, 1'b1, 1'b1, 3'd0);
        checkOutput("mwr.sd_rw", {31'd0, sd_rw}, 32'd1);
        checkOutput("mwr.addr", sd_address, 32'h0000_1000);
        checkOutput("mwr.wdata", {16'd0, sd_write_data}, 32'h0000_BEEF);
        checkOutput("mwr.blen", {31'd0, sd_burst_len}, 32'd1);
        sd_bursting = 1'b1;
        applyStimulus();
        checkCore("mburst", S_BURST, 1'b1, 1'b1, 3'd0);
        m_rw_req = 1'b0; v_rw_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("iso.v_bursting", {31'd0, v_bursting}, 32'd0);
            checkOutput("iso.m_bursting", {31'd0, m_bursting}, 32'd1);
            checkOutput("iso.owner", {31'd0, owner_mmu}, 32'd1);
            if (i < 7) applyStimulus();
        end
        sd_bursting = 1'b0;
        applyStimulus();
        checkCore("mgap", S_GAP, 1'b0, 1'b1, 3'd0);
        v_rw_req = 1'b0;
        applyStimulus();
        checkCore("midle", S_IDLE, 1'b0, 1'b1, 3'd0);

        // Simultaneous requests: video wins, MMU served after video releases
        v_rw_req = 1'b1; m_rw_req = 1'b1;
        applyStimulus();
        checkCore("both", S_REQ, 1'b1, 1'b0, 3'd1);
        checkOutput("both.sd_rw", {31'd0, sd_rw}, 32'd0);
        checkOutput("both.addr", sd_address, 32'h0000_2000);
        sd_bursting = 1'b1;
        applyStimulus();
        v_rw_req = 1'b0;
        checkOutput("both.v_bursting", {31'd0, v_bursting}, 32'd1);
        checkOutput("both.m_bursting", {31'd0, m_bursting}, 32'd0);
        sd_bursting = 1'b0;
        applyStimulus();
        checkCore("both.gap", S_GAP, 1'b0, 1'b0, 3'd1);
        applyStimulus();
        checkCore("both.idle", S_IDLE, 1'b0, 1'b0, 3'd1);
        applyStimulus();
        checkCore("both.mgrant", S_REQ, 1'b1, 1'b1, 3'd0);
        sd_bursting = 1'b1;
        applyStimulus();
        m_rw_req = 1'b0; sd_bursting = 1'b0;
        applyStimulus();
        applyStimulus();
        checkCore("both.end", S_IDLE, 1'b0, 1'b1, 3'd0);

        // Starvation: four video wins while the MMU waits, fifth grant to the MMU
        m_rw_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v_rw_req = 1'b1;
            applyStimulus();
            checkCore("starve.vgrant", S_REQ, 1'b1, 1'b0, 3'(i + 1));
            sd_bursting = 1'b1;
            applyStimulus();
            v_rw_req = 1'b0; sd_bursting = 1'b0;
            applyStimulus();
            applyStimulus();
        end
        v_rw_req = 1'b1;
        applyStimulus();
        checkCore("starve.mgrant", S_REQ, 1'b1, 1'b1, 3'd0);
        sd_bursting = 1'b1;
        applyStimulus();
        m_rw_req = 1'b0;
        applyStimulus();
        checkOutput("starve.v_bursting", {31'd0, v_bursting}, 32'd0);
        sd_bursting = 1'b0;
        applyStimulus();
        applyStimulus();

        // Abort: video request held two cycles then dropped before any burst
        applyStimulus();
        checkCore("abort.grant", S_REQ, 1'b1, 1'b0, 3'd0);
        applyStimulus();
        checkCore("abort.hold", S_REQ, 1'b1, 1'b0, 3'd0);
        v_rw_req = 1'b0;
        applyStimulus();
        checkCore("abort.gap", S_GAP, 1'b0, 1'b0, 3'd0);
        checkOutput("abort.v_bursting", {31'd0, v_bursting}, 32'd0);
        applyStimulus();
        checkCore("abort.idle", S_IDLE, 1'b0, 1'b0, 3'd0);

        // sd_bursting in IDLE is ignored
        sd_bursting = 1'b1;
        applyStimulus();
        checkCore("idle.ignore", S_IDLE, 1'b0, 1'b0, 3'd0);
        sd_bursting = 1'b0;

        // Back-to-back video burst, then reset in BURST
        v_rw_req = 1'b1; m_rw_req = 1'b1;
        applyStimulus();
        checkCore("b2b.grant", S_REQ, 1'b1, 1'b0, 3'd1);
        m_rw_req = 1'b0; sd_bursting = 1'b1;
        applyStimulus();
        sd_bursting = 1'b0;
        applyStimulus();
        checkCore("b2b.stay", S_BURST, 1'b1, 1'b0, 3'd1);
        reset = 1'b0;
        applyStimulus();
        checkCore("rst.mid", S_IDLE, 1'b0, 1'b0, 3'd0);
        reset = 1'b1; v_rw_req = 1'b0;
        applyStimulus();
        checkCore("rst.after", S_IDLE, 1'b0, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
